// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: two-master arbiter sharing one SRAM-like bus between the
// instruction-fetch port (id 0) and the execute-stage data port (id 1).
// A request stays selected until the slave accepts it or the master withdraws.
// The issue order of accepted requests is kept in a small ID FIFO. Each
// data_ok/rdata beat from the slave is routed to the master that issued it.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   inst_* / data_*         master request fields in; addr_ok/data_ok/rdata/ex out
//   bus_*                   request fields to slave; addr_ok/data_ok/rdata/ex in
//   err                     sticky flag: slave returned data with nothing outstanding
module mem_req_arbiter #(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [2:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic [1:0]  inst_ex,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [1:0]  data_ex,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [2:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  bus_ex,
    output logic        err
);

    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    logic                   lock_q, lock_d;
    logic                   lock_id_q, lock_id_d;
    logic [1:0]             starve_q, starve_d;
    logic [OUTSTANDING-1:0] id_mem_q, id_mem_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   err_q, err_d;

    logic grant_id;
    logic locked_req;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic pop;
    logic head_id;

    // Grant selection: held lock, then starvation relief for fetch, then data priority.
    always_comb begin
        grant_id   = ID_INST;
        locked_req = lock_id_q ? data_req : inst_req;
        if (lock_q && locked_req) begin
            grant_id = lock_id_q;
        end else if (starve_q == 2'd3 && inst_req) begin
            grant_id = ID_INST;
        end else if (data_req) begin
            grant_id = ID_DATA;
        end
    end

    // Bus drive and combinational return paths.
    always_comb begin
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        head_id    = id_mem_q[rd_ptr_q];

        bus_req   = (grant_id ? data_req : inst_req) && !fifo_full && !reset;
        bus_wr    = grant_id ? data_wr    : inst_wr;
        bus_size  = grant_id ? data_size  : inst_size;
        bus_addr  = grant_id ? data_addr  : inst_addr;
        bus_wdata = grant_id ? data_wdata : inst_wdata;

        accept       = bus_req && bus_addr_ok;
        inst_addr_ok = accept && (grant_id == ID_INST);
        data_addr_ok = accept && (grant_id == ID_DATA);
        inst_ex      = (bus_req && grant_id == ID_INST) ? bus_ex : 2'b00;
        data_ex      = (bus_req && grant_id == ID_DATA) ? bus_ex : 2'b00;

        pop          = bus_data_ok && !fifo_empty && !reset;
        inst_data_ok = pop && (head_id == ID_INST);
        data_data_ok = pop && (head_id == ID_DATA);
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
        err          = err_q;
    end

    // Next-state: lock, starvation counter, order FIFO, error flag.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        starve_d  = starve_q;
        id_mem_d  = id_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q;

        // A withdrawn locked request releases the lock; a stalled issue (re)arms it.
        if (lock_q && !locked_req) begin
            lock_d = 1'b0;
        end
        if (bus_req) begin
            lock_d    = !bus_addr_ok;
            lock_id_d = grant_id;
        end

        if (accept && grant_id == ID_INST) begin
            starve_d = 2'd0;
        end else if (accept && inst_req && starve_q != 2'd3) begin
            starve_d = starve_q + 2'd1;
        end

        // accept already implies the FIFO was not full at the start of the cycle.
        if (accept) begin
            id_mem_d[wr_ptr_q] = grant_id;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus_data_ok && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= ID_INST;
            starve_q  <= 2'd0;
            id_mem_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            starve_q  <= starve_d;
            id_mem_q  <= id_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (OUTSTANDING = 4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// before the next rising edge.
module tb_mem_req_arbiter;

    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [2:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [1:0]  inst_ex;
    logic        data_req, data_wr;
    logic [2:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [1:0]  data_ex;
    logic        bus_req, bus_wr;
    logic [2:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_ex;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_ex(inst_ex),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .data_ex(data_ex),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .bus_ex(bus_ex),
        .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 3'd1; inst_addr = IA; inst_wdata = 32'hAAAA_0000;
        data_req = 1'b0; data_wr = 1'b1; data_size = 3'd2; data_addr = DA; data_wdata = 32'hBBBB_0000;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0; bus_ex = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_ex = 2'b01;
        tick();
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL rst_addr_ok: got %b want 00", {inst_addr_ok, data_addr_ok}); end
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_data_ok: got %b want 00", {inst_data_ok, data_data_ok}); end
        checks++; if ({inst_ex, data_ex} !== 4'b0000) begin errors++; $display("FAIL rst_ex: got %b want 0000", {inst_ex, data_ex}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        idle_inputs();
        reset = 1'b0;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err_after: got %b want 0", err); end
    endtask

    // Both masters request every cycle; data wins until starve saturates at 3.
    task automatic test_interleave();
        int          exp_gnt [5] = '{1, 1, 1, 0, 1};
        int          exp_pop [5] = '{-1, 1, 1, 1, 0};
        logic [31:0] exp_addr;
        do_reset();
        inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus_data_ok = (k != 0);
            bus_rdata   = 32'hC0 + 32'(k);
            exp_addr    = (exp_gnt[k] == 1) ? DA : IA;
            #1;
            checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL il_bus_req c%0d: got %b want 1", k, bus_req); end
            checks++; if (bus_addr !== exp_addr) begin errors++; $display("FAIL il_bus_addr c%0d: got %h want %h", k, bus_addr, exp_addr); end
            checks++; if (bus_wr !== (exp_gnt[k] == 1)) begin errors++; $display("FAIL il_bus_wr c%0d: got %b", k, bus_wr); end
            checks++; if ({inst_addr_ok, data_addr_ok} !== {exp_gnt[k] == 0, exp_gnt[k] == 1}) begin
                errors++; $display("FAIL il_addr_ok c%0d: got %b (inst,data)", k, {inst_addr_ok, data_addr_ok}); end
            checks++; if ({inst_data_ok, data_data_ok} !== {exp_pop[k] == 0, exp_pop[k] == 1}) begin
                errors++; $display("FAIL il_data_ok c%0d: got %b (inst,data)", k, {inst_data_ok, data_data_ok}); end
            tick();
        end
        inst_req = 1'b0; data_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hD5;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL il_drain: got %b want 01", {inst_data_ok, data_data_ok}); end
        checks++; if (data_rdata !== 32'hD5) begin errors++; $display("FAIL il_drain_rdata: got %h want d5", data_rdata); end
        tick();
        idle_inputs();
    endtask

    task automatic test_lock_hold();
        do_reset();
        inst_req = 1'b1; data_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_addr_ok = (k == 3);
            #1;
            checks++; if (bus_addr !== DA || bus_req !== 1'b1) begin errors++; $display("FAIL lk_data_hold c%0d: got addr %h req %b want %h 1", k, bus_addr, bus_req, DA); end
            checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL lk_inst_aok c%0d: got %b want 0", k, inst_addr_ok); end
            checks++; if (data_addr_ok !== (k == 3)) begin errors++; $display("FAIL lk_data_aok c%0d: got %b", k, data_addr_ok); end
            tick();
        end
        // Fetch stalls alone, then data arrives: the bus must stay on fetch.
        data_req = 1'b0; bus_addr_ok = 1'b0;
        tick();
        data_req = 1'b1;
        #1;
        checks++; if (bus_addr !== IA) begin errors++; $display("FAIL lk_inst_hold: got %h want %h", bus_addr, IA); end
        tick();
        bus_addr_ok = 1'b1;
        #1;
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL lk_inst_accept: got %b want 10", {inst_addr_ok, data_addr_ok}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_ordering();
        logic [31:0] rd [3] = '{32'h11, 32'h22, 32'h33};
        logic [1:0]  dest [3] = '{2'b10, 2'b01, 2'b10};
        do_reset();
        bus_addr_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst_req = (k != 1); data_req = (k == 1);
            #1;
            checks++; if ({inst_addr_ok, data_addr_ok} !== dest[k]) begin errors++; $display("FAIL ord_issue%0d: got %b want %b", k, {inst_addr_ok, data_addr_ok}, dest[k]); end
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            bus_data_ok = 1'b1; bus_rdata = rd[k];
            #1;
            checks++; if ({inst_data_ok, data_data_ok} !== dest[k]) begin errors++; $display("FAIL ord_beat%0d: got %b want %b", k, {inst_data_ok, data_data_ok}, dest[k]); end
            checks++; if ((dest[k][1] ? inst_rdata : data_rdata) !== rd[k]) begin errors++; $display("FAIL ord_rdata%0d: got %h want %h", k, dest[k][1] ? inst_rdata : data_rdata, rd[k]); end
            tick();
        end
        idle_inputs();
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ord_err: got %b want 0", err); end
    endtask

    task automatic test_full();
        do_reset();
        inst_req = 1'b1; bus_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b want 1", k, inst_addr_ok); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (bus_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL full_block%0d: got req %b aok %b want 0 0", k, bus_req, inst_addr_ok); end
            tick();
        end
        bus_data_ok = 1'b1; bus_rdata = 32'h44;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_req: got %b want 0", bus_req); end
        checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL full_pop_dok: got %b want 1", inst_data_ok); end
        tick();
        bus_data_ok = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b1 || inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_resume: got req %b aok %b want 1 1", bus_req, inst_addr_ok); end
        tick();
        idle_inputs();
    endtask

    task automatic test_exception();
        do_reset();
        inst_req = 1'b1; data_req = 1'b1; bus_ex = 2'b10;
        #1;
        checks++; if (data_ex !== 2'b10 || inst_ex !== 2'b00) begin errors++; $display("FAIL ex_route_data: got data %b inst %b want 10 00", data_ex, inst_ex); end
        checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL ex_no_aok: got %b want 0", data_addr_ok); end
        tick();
        data_req = 1'b0; bus_ex = 2'b01;
        #1;
        checks++; if (bus_req !== 1'b1 || bus_addr !== IA) begin errors++; $display("FAIL ex_inst_grant: got req %b addr %h want 1 %h", bus_req, bus_addr, IA); end
        checks++; if (inst_ex !== 2'b01 || data_ex !== 2'b00) begin errors++; $display("FAIL ex_route_inst: got inst %b data %b want 01 00", inst_ex, data_ex); end
        tick();
        bus_ex = 2'b00; bus_addr_ok = 1'b1;
        #1;
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL ex_inst_accept: got %b want 1", inst_addr_ok); end
        tick();
        idle_inputs();
        bus_data_ok = 1'b1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL ex_beat0: got %b want 10", {inst_data_ok, data_data_ok}); end
        tick();
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL ex_no_push: got %b want 00", {inst_data_ok, data_data_ok}); end
        tick();
        bus_data_ok = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ex_err: got %b want 1", err); end
        idle_inputs();
    endtask

    task automatic test_error_reset();
        do_reset();
        bus_data_ok = 1'b1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL er_no_fwd: got %b want 00", {inst_data_ok, data_data_ok}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL er_err_same: got %b want 0", err); end
        tick();
        bus_data_ok = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL er_err_set: got %b want 1", err); end
        inst_req = 1'b1; bus_addr_ok = 1'b1;
        tick();
        inst_req = 1'b0; data_req = 1'b1;
        tick();
        data_req = 1'b0; bus_addr_ok = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL er_sticky: got %b want 1", err); end
        reset = 1'b1;
        inst_req = 1'b1;
        #1;
        checks++; if (err !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL er_async_rst: got err %b req %b want 0 0", err, bus_req); end
        tick();
        inst_req = 1'b0;
        reset = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'h55;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL er_late_beat: got %b want 00", {inst_data_ok, data_data_ok}); end
        tick();
        bus_data_ok = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL er_err_after_rst: got %b want 1", err); end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        test_reset();
        test_interleave();
        test_lock_hold();
        test_ordering();
        test_full();
        test_exception();
        test_error_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
